// File: rtl/csel_adder_pipe.sv
// Pipelined carry-select adder/subtractor: one register stage per BLOCK-bit slice, valid/ready on both ends.
// Optional signed-overflow output Ovf is enabled by defining CSEL_ADDER_OVF_EN.
module csel_adder_pipe #(
   parameter int WIDTH = 16,
   parameter int BLOCK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Sum,
   output logic             Cout
`ifdef CSEL_ADDER_OVF_EN
   ,
   output logic             Ovf
`endif
);

   localparam int NUM_BLK = (BLOCK >= 1) ? (WIDTH / BLOCK) : 1;

   if (BLOCK < 1) begin : g_bad_block
      $error("csel_adder_pipe: BLOCK must be at least 1");
   end else if ((WIDTH % BLOCK) != 0) begin : g_bad_width
      $error("csel_adder_pipe: WIDTH must be a multiple of BLOCK");
   end

   // Ripple chain of full adders over one slice; returns {carry_out, sum}.
   function automatic logic [BLOCK:0] ripple(input logic [BLOCK-1:0] a,
                                             input logic [BLOCK-1:0] b,
                                             input logic             cin);
      logic [BLOCK-1:0] s;
      logic             cy;
      cy = cin;
      s  = '0;
      for (int i = 0; i < BLOCK; i++) begin
         s[i] = a[i] ^ b[i] ^ cy;
         cy   = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
      end
      return {cy, s};
   endfunction

   // Index k holds what stage k consumes; index 0 is the conditioned input beat.
   logic [WIDTH-1:0] a_pipe [0:NUM_BLK];
   logic [WIDTH-1:0] b_pipe [0:NUM_BLK];
   logic [WIDTH-1:0] s_pipe [0:NUM_BLK];
   logic             c_pipe [0:NUM_BLK];
   logic             v_pipe [0:NUM_BLK];
   logic             en;

   assign en        = ~out_valid | out_ready;
   assign in_ready  = en;

   assign a_pipe[0] = A;
   assign b_pipe[0] = sub ? ~B : B;
   assign c_pipe[0] = sub ? 1'b1 : Cin;
   assign v_pipe[0] = in_valid;
   assign s_pipe[0] = '0;

`ifdef CSEL_ADDER_OVF_EN
   logic last_sum_msb;
   logic last_cout;
   logic ovf_reg;
`endif

   genvar gi;
   for (gi = 0; gi < NUM_BLK; gi++) begin : g_stage
      localparam int LO = gi * BLOCK;

      logic [BLOCK-1:0] a_sl, b_sl;
      logic [BLOCK-1:0] sum0, sum1, sum_sel;
      logic             co0, co1, c_sel;
      logic [WIDTH-1:0] s_next;
      logic [WIDTH-1:0] a_reg, b_reg, s_reg;
      logic             c_reg, v_reg;

      assign a_sl = a_pipe[gi][LO +: BLOCK];
      assign b_sl = b_pipe[gi][LO +: BLOCK];

      // Both carry hypotheses are computed up front; the registered carry only drives the mux.
      assign {co0, sum0} = ripple(a_sl, b_sl, 1'b0);
      assign {co1, sum1} = ripple(a_sl, b_sl, 1'b1);
      assign sum_sel     = c_pipe[gi] ? sum1 : sum0;
      assign c_sel       = c_pipe[gi] ? co1  : co0;

      always_comb begin
         s_next              = s_pipe[gi];
         s_next[LO +: BLOCK] = sum_sel;
      end

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            v_reg <= 1'b0;
            c_reg <= 1'b0;
            s_reg <= '0;
         end else if (en) begin
            v_reg <= v_pipe[gi];
            c_reg <= c_sel;
            s_reg <= s_next;
         end
      end

      // Operand skew registers carry the not-yet-added upper slices alongside the beat.
      always_ff @(posedge clk) begin
         if (en) begin
            a_reg <= a_pipe[gi];
            b_reg <= b_pipe[gi];
         end
      end

      assign a_pipe[gi+1] = a_reg;
      assign b_pipe[gi+1] = b_reg;
      assign s_pipe[gi+1] = s_next_q(s_reg);
      assign c_pipe[gi+1] = c_reg;
      assign v_pipe[gi+1] = v_reg;

`ifdef CSEL_ADDER_OVF_EN
      if (gi == NUM_BLK - 1) begin : g_last
         assign last_sum_msb = sum_sel[BLOCK-1];
         assign last_cout    = c_sel;
      end
`endif
   end

   function automatic logic [WIDTH-1:0] s_next_q(input logic [WIDTH-1:0] v);
      return v;
   endfunction

   assign out_valid = v_pipe[NUM_BLK];
   assign Sum       = s_pipe[NUM_BLK];
   assign Cout      = c_pipe[NUM_BLK];

`ifdef CSEL_ADDER_OVF_EN
   // Carry into the MSB is recovered as a ^ b ^ sum at that bit position.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ovf_reg <= 1'b0;
      end else if (en) begin
         ovf_reg <= a_pipe[NUM_BLK-1][WIDTH-1] ^ b_pipe[NUM_BLK-1][WIDTH-1]
                    ^ last_sum_msb ^ last_cout;
      end
   end

   assign Ovf = ovf_reg;
`endif

endmodule

// File: tb/tb_csel_adder_pipe.sv
// Scoreboard bench for csel_adder_pipe (WIDTH=16, BLOCK=4); checks Ovf too when CSEL_ADDER_OVF_EN is defined.
module tb_csel_adder_pipe;

   localparam int W   = 16;
   localparam int LAT = 4;

   logic         clk = 1'b0;
   logic         rst_n, in_valid, in_ready, Cin, sub, out_valid, out_ready, Cout;
   logic [W-1:0] A, B, Sum;
`ifdef CSEL_ADDER_OVF_EN
   logic         Ovf;
`endif

   always #5 clk = ~clk;

   csel_adder_pipe #(.WIDTH(W), .BLOCK(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .Cin       (Cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .Sum       (Sum),
      .Cout      (Cout)
`ifdef CSEL_ADDER_OVF_EN
      ,
      .Ovf       (Ovf)
`endif
   );

   typedef struct packed {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
      logic [31:0]  cyc;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   n_chk   = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   bit   lat_chk = 1'b1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic ci, input logic sb);
      exp_t         e;
      logic [W-1:0] be;
      logic         c0;
      logic [W:0]   r;
      be     = sb ? ~b : b;
      c0     = sb ? 1'b1 : ci;
      r      = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, c0};
      e.sum  = r[W-1:0];
      e.cout = r[W];
      e.ovf  = (a[W-1] == be[W-1]) && (r[W-1] != a[W-1]);
      e.cyc  = 32'd0;
      return e;
   endfunction

   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         sb_q.delete();
      end else begin
         if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_out", 32'd1, 32'd0);
            end else begin
               mon_e = sb_q.pop_front();
               $display("OUT cyc=%0d Sum=%h Cout=%b expect Sum=%h Cout=%b", cyc, Sum, Cout,
                        mon_e.sum, mon_e.cout);
               chk("sum", {16'd0, Sum}, {16'd0, mon_e.sum});
               chk("cout", {31'd0, Cout}, {31'd0, mon_e.cout});
`ifdef CSEL_ADDER_OVF_EN
               chk("ovf", {31'd0, Ovf}, {31'd0, mon_e.ovf});
`endif
               if (lat_chk) chk("latency", cyc - mon_e.cyc, LAT);
            end
         end
         if (in_valid && in_ready) begin
            mon_e     = model(A, B, Cin, sub);
            mon_e.cyc = cyc;
            sb_q.push_back(mon_e);
         end
      end
   end

   // Called just after a rising edge; returns just after the edge that accepted the beat.
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci, input logic sb);
      bit ok;
      ok = 1'b0;
      A = a; B = b; Cin = ci; sub = sb; in_valid = 1'b1;
      for (int k = 0; k < 100 && !ok; k++) begin
         @(negedge clk);
         if (in_ready) ok = 1'b1;
      end
      if (!ok) chk("send_timeout", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int k = 0; k < 100 && sb_q.size() != 0; k++) @(negedge clk);
      chk("drain", sb_q.size(), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; A = '0; B = '0; Cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_sum", {16'd0, Sum}, 32'd0);
      chk("rst_cout", {31'd0, Cout}, 32'd0);
`ifdef CSEL_ADDER_OVF_EN
      chk("rst_ovf", {31'd0, Ovf}, 32'd0);
`endif
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      chk("in_ready_after_rst", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;

      // Full carry ripple, then subtract with and without borrow.
      send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
      drain();
      send(16'h0005, 16'h0007, 1'b1, 1'b1);
      send(16'h0007, 16'h0005, 1'b0, 1'b1);
      drain();
      send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
      send(16'h8000, 16'h0001, 1'b0, 1'b1);
      send(16'h0000, 16'h0000, 1'b1, 1'b0);
      drain();

      // Back-to-back streaming with latency checked per beat.
      for (int i = 0; i < 8; i++) begin
         send(16'(i), 16'(32'h1000 * i), 1'b0, 1'b0);
         chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
      end
      drain();

      // Backpressure: hold the first result for three cycles.
      lat_chk   = 1'b0;
      out_ready = 1'b0;
      fork
         begin
            for (int i = 0; i < 6; i++)
               send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
         end
         begin
            bit seen;
            seen = 1'b0;
            for (int k = 0; k < 50 && !seen; k++) begin
               @(negedge clk);
               if (out_valid) seen = 1'b1;
            end
            chk("bp_out_valid_seen", {31'd0, seen}, 32'd1);
            for (int j = 0; j < 3; j++) begin
               if (j > 0) @(negedge clk);
               chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
               chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
               chk("bp_sum_hold", {16'd0, Sum}, {16'd0, sb_q[0].sum});
               chk("bp_cout_hold", {31'd0, Cout}, {31'd0, sb_q[0].cout});
            end
            @(posedge clk); #1 out_ready = 1'b1;
         end
      join
      drain();
      lat_chk = 1'b1;

      // Reset with three beats in flight.
      send(16'h1234, 16'h1111, 1'b0, 1'b0);
      send(16'h4321, 16'h0101, 1'b1, 1'b0);
      send(16'hAAAA, 16'h5555, 1'b0, 1'b1);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("midrst_sum", {16'd0, Sum}, 32'd0);
      chk("midrst_cout", {31'd0, Cout}, 32'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk("no_stale_beat", {31'd0, out_valid}, 32'd0);
      end
      @(posedge clk); #1;

      // Random traffic under random consumer stalls.
      lat_chk = 1'b0;
      fork
         begin
            for (int i = 0; i < 12; i++)
               send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
         end
         begin
            for (int j = 0; j < 40; j++) begin
               @(posedge clk); #1 out_ready = 1'($urandom_range(0, 1));
            end
            out_ready = 1'b1;
         end
      join
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
